// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU operand sequencer and the ALSU datapath:
// operand/opcode widths, default abort timeout, sequencer states and the
// opcode encodings both sides agree on.
package alsu_pkg;

    localparam int ALSU_DATA_WIDTH = 4;
    localparam int ALSU_OP_WIDTH   = 6;
    localparam int ALSU_TIMEOUT    = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        EXEC   = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

    // Opcode map shared with the combinational ALSU (40 operations, 0..39).
    localparam logic [ALSU_OP_WIDTH-1:0] OP_ADD  = 6'd0;
    localparam logic [ALSU_OP_WIDTH-1:0] OP_SUB  = 6'd1;
    localparam logic [ALSU_OP_WIDTH-1:0] OP_AND  = 6'd2;
    localparam logic [ALSU_OP_WIDTH-1:0] OP_OR   = 6'd3;
    localparam logic [ALSU_OP_WIDTH-1:0] OP_XOR  = 6'd4;
    localparam logic [ALSU_OP_WIDTH-1:0] OP_NOT  = 6'd5;
    localparam logic [ALSU_OP_WIDTH-1:0] OP_INC  = 6'd11;
    localparam logic [ALSU_OP_WIDTH-1:0] OP_DEC  = 6'd12;
    localparam logic [ALSU_OP_WIDTH-1:0] OP_LAST = 6'd39;

    // True when the opcode names an operation the ALSU implements.
    function automatic logic op_is_legal(input logic [ALSU_OP_WIDTH-1:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alsu_operand_sequencer_if.sv
// Bundle of every signal between the operand sequencer, its producer, the
// combinational ALSU and the result consumer. The slave modport is the
// sequencer's view; the master modport is the surrounding environment.
interface alsu_operand_sequencer_if
    import alsu_pkg::*;
#(
    parameter int DATA_WIDTH = ALSU_DATA_WIDTH,
    parameter int OP_WIDTH   = ALSU_OP_WIDTH
) ();

    logic [DATA_WIDTH-1:0] Data_In;
    logic [OP_WIDTH-1:0]   Op_In;
    logic                  Sel_In;
    logic                  Data_Valid;
    logic                  Data_Ready;

    logic [DATA_WIDTH-1:0] A_Out;
    logic [DATA_WIDTH-1:0] B_Out;
    logic [OP_WIDTH-1:0]   Op_Out;
    logic                  Sel_Out;
    logic [DATA_WIDTH-1:0] Alsu_Result;
    logic                  Alsu_Neg_Flag;

    logic [DATA_WIDTH-1:0] Result;
    logic                  Negative_Sign_Flag;
    logic                  Result_Valid;
    logic                  Result_Ack;

    modport slave (
        input  Data_In, Op_In, Sel_In, Data_Valid,
        output Data_Ready,
        output A_Out, B_Out, Op_Out, Sel_Out,
        input  Alsu_Result, Alsu_Neg_Flag,
        output Result, Negative_Sign_Flag, Result_Valid,
        input  Result_Ack
    );

    modport master (
        output Data_In, Op_In, Sel_In, Data_Valid,
        input  Data_Ready,
        input  A_Out, B_Out, Op_Out, Sel_Out,
        output Alsu_Result, Alsu_Neg_Flag,
        input  Result, Negative_Sign_Flag, Result_Valid,
        output Result_Ack
    );

endinterface

// File: rtl/alsu_timeout_counter.sv
// Cycle counter for the wait-for-operand-B window. Counts while enabled,
// holds at TIMEOUT-1, and flags the terminal cycle combinationally so the
// sequencer can abort on the same edge.
module alsu_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count up while waiting, stop at the last count, restart on clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = enable && (count == LAST);

endmodule

// File: rtl/alsu_operand_sequencer.sv
// Front/back end around the combinational 4-bit ALSU: gathers A (with opcode
// and select) then B from a shared beat bus, holds them for one execute
// cycle, captures the result and flag, and presents them until acknowledged.
// A missing B beat aborts the operation after TIMEOUT cycles.
module alsu_operand_sequencer
    import alsu_pkg::*;
#(
    parameter int TIMEOUT = ALSU_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    alsu_operand_sequencer_if.slave  bus,
    output logic                     Busy,
    output logic                     Timeout_Err
);

    seq_state_t state;
    seq_state_t next_state;

    logic transfer;
    logic wait_tick;
    logic timer_clear;
    logic timer_terminal;

    assign bus.Data_Ready = (state == IDLE) || (state == WAIT_B);
    assign Busy           = (state != IDLE);
    assign transfer       = bus.Data_Valid && bus.Data_Ready;

    // The timer only runs in WAIT_B cycles without a B beat, so a beat in
    // the terminal cycle masks the abort.
    assign wait_tick   = (state == WAIT_B) && !bus.Data_Valid;
    assign timer_clear = (state != WAIT_B);

    alsu_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .enable   (wait_tick),
        .terminal (timer_terminal)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode for the A / B / execute / hold sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (transfer) begin
                    next_state = WAIT_B;
                end
            end
            WAIT_B: begin
                if (transfer) begin
                    next_state = EXEC;
                end else if (timer_terminal) begin
                    next_state = IDLE;
                end
            end
            EXEC: begin
                next_state = HOLD;
            end
            HOLD: begin
                if (bus.Result_Ack) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand registers: A, opcode and select on the A beat, B on the B beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.A_Out   <= '0;
            bus.B_Out   <= '0;
            bus.Op_Out  <= '0;
            bus.Sel_Out <= 1'b0;
        end else begin
            if ((state == IDLE) && transfer) begin
                bus.A_Out   <= bus.Data_In;
                bus.Op_Out  <= bus.Op_In;
                bus.Sel_Out <= bus.Sel_In;
            end
            if ((state == WAIT_B) && transfer) begin
                bus.B_Out <= bus.Data_In;
            end
        end
    end

    // Result capture at the end of the execute cycle; held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Result             <= '0;
            bus.Negative_Sign_Flag <= 1'b0;
        end else if (state == EXEC) begin
            bus.Result             <= bus.Alsu_Result;
            bus.Negative_Sign_Flag <= bus.Alsu_Neg_Flag;
        end
    end

    // Registered status: result-valid tracks HOLD, abort pulses for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Result_Valid <= 1'b0;
            Timeout_Err      <= 1'b0;
        end else begin
            bus.Result_Valid <= (next_state == HOLD);
            Timeout_Err      <= (state == WAIT_B) && !transfer && timer_terminal;
        end
    end

endmodule

// File: tb/tb_alsu_operand_sequencer.sv
// Directed self-checking bench for the ALSU operand sequencer. The bench
// plays producer, ALSU and consumer through the interface's signals.
module tb_alsu_operand_sequencer;
    import alsu_pkg::*;

    logic clk;
    logic rst;
    logic busy;
    logic timeout_err;

    int checks;
    int failures;

    alsu_operand_sequencer_if bus ();

    alsu_operand_sequencer #(
        .TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .Busy        (busy),
        .Timeout_Err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [3:0] data, input logic [5:0] op, input logic sel);
        bus.Data_Valid = 1'b1;
        bus.Data_In    = data;
        bus.Op_In      = op;
        bus.Sel_In     = sel;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Data_Valid    = 1'b0;
        bus.Data_In       = 4'h0;
        bus.Op_In         = 6'd0;
        bus.Sel_In        = 1'b0;
        bus.Alsu_Result   = 4'h0;
        bus.Alsu_Neg_Flag = 1'b0;
        bus.Result_Ack    = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.A_Out, bus.B_Out, bus.Op_Out, bus.Sel_Out, bus.Result,
             bus.Negative_Sign_Flag, bus.Result_Valid, timeout_err} !== 25'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got A=%0h B=%0h Op=%0d Sel=%0b R=%0h N=%0b V=%0b E=%0b required all 0",
                     bus.A_Out, bus.B_Out, bus.Op_Out, bus.Sel_Out, bus.Result,
                     bus.Negative_Sign_Flag, bus.Result_Valid, timeout_err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.Data_Ready, busy} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_ready_busy got ready=%0b busy=%0b required ready=1 busy=0",
                     bus.Data_Ready, busy);
        end
    endtask

    task automatic test_basic_op();
        drive_beat(4'h5, 6'd12, 1'b1);
        tick();
        checks++;
        if ({bus.A_Out, bus.Op_Out, bus.Sel_Out, bus.Data_Ready, busy} !== {4'h5, 6'd12, 1'b1, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL basic_a_beat got A=%0h Op=%0d Sel=%0b ready=%0b busy=%0b required A=5 Op=12 Sel=1 ready=1 busy=1",
                     bus.A_Out, bus.Op_Out, bus.Sel_Out, bus.Data_Ready, busy);
        end
        drive_beat(4'h3, 6'd33, 1'b0);
        tick();
        bus.Data_Valid    = 1'b0;
        bus.Alsu_Result   = 4'h4;
        bus.Alsu_Neg_Flag = 1'b0;
        checks++;
        if ({bus.A_Out, bus.B_Out, bus.Op_Out, bus.Sel_Out, bus.Data_Ready, bus.Result_Valid} !==
            {4'h5, 4'h3, 6'd12, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL basic_exec_entry got A=%0h B=%0h Op=%0d Sel=%0b ready=%0b valid=%0b required A=5 B=3 Op=12 Sel=1 ready=0 valid=0",
                     bus.A_Out, bus.B_Out, bus.Op_Out, bus.Sel_Out, bus.Data_Ready, bus.Result_Valid);
        end
        #3;
        checks++;
        if ({bus.A_Out, bus.B_Out, bus.Sel_Out} !== {4'h5, 4'h3, 1'b1}) begin
            failures++;
            $display("[TB] FAIL basic_exec_stable got A=%0h B=%0h Sel=%0b required A=5 B=3 Sel=1",
                     bus.A_Out, bus.B_Out, bus.Sel_Out);
        end
        tick();
        checks++;
        if ({bus.Result, bus.Negative_Sign_Flag, bus.Result_Valid} !== {4'h4, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL basic_result got R=%0h N=%0b V=%0b required R=4 N=0 V=1",
                     bus.Result, bus.Negative_Sign_Flag, bus.Result_Valid);
        end
        bus.Result_Ack = 1'b1;
        tick();
        bus.Result_Ack = 1'b0;
        checks++;
        if ({bus.Result_Valid, busy, bus.Result} !== {1'b0, 1'b0, 4'h4}) begin
            failures++;
            $display("[TB] FAIL basic_release got V=%0b busy=%0b R=%0h required V=0 busy=0 R=4",
                     bus.Result_Valid, busy, bus.Result);
        end
    endtask

    task automatic test_decrement_hold();
        drive_beat(4'h0, OP_DEC, 1'b0);
        tick();
        drive_beat(4'h7, 6'd0, 1'b1);
        tick();
        bus.Data_Valid    = 1'b0;
        bus.Alsu_Result   = 4'hF;
        bus.Alsu_Neg_Flag = 1'b1;
        tick();
        bus.Alsu_Result   = 4'h2;
        bus.Alsu_Neg_Flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.Result, bus.Negative_Sign_Flag, bus.Result_Valid, busy} !== {4'hF, 1'b1, 1'b1, 1'b1}) begin
                failures++;
                $display("[TB] FAIL dec_hold cycle=%0d got R=%0h N=%0b V=%0b busy=%0b required R=f N=1 V=1 busy=1",
                         i, bus.Result, bus.Negative_Sign_Flag, bus.Result_Valid, busy);
            end
            tick();
        end
        bus.Result_Ack = 1'b1;
        tick();
        bus.Result_Ack = 1'b0;
        checks++;
        if ({bus.Result_Valid, busy, bus.Result, bus.Negative_Sign_Flag} !== {1'b0, 1'b0, 4'hF, 1'b1}) begin
            failures++;
            $display("[TB] FAIL dec_release got V=%0b busy=%0b R=%0h N=%0b required V=0 busy=0 R=f N=1",
                     bus.Result_Valid, busy, bus.Result, bus.Negative_Sign_Flag);
        end
        tick();
        checks++;
        if ({bus.Result_Valid, busy} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL dec_idle got V=%0b busy=%0b required V=0 busy=0", bus.Result_Valid, busy);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        logic exp_err;
        logic exp_busy;
        drive_beat(4'hA, 6'd4, 1'b1);
        tick();
        bus.Data_Valid = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_err  = (i == 15);
            exp_busy = (i < 15);
            if (timeout_err) pulses++;
            checks++;
            if ({timeout_err, busy, bus.Result_Valid} !== {exp_err, exp_busy, 1'b0}) begin
                failures++;
                $display("[TB] FAIL timeout_seq tick=%0d got err=%0b busy=%0b V=%0b required err=%0b busy=%0b V=0",
                         i, timeout_err, busy, bus.Result_Valid, exp_err, exp_busy);
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("[TB] FAIL timeout_pulse_count got %0d required 1", pulses);
        end
        checks++;
        if ({bus.A_Out, bus.Op_Out, bus.Sel_Out} !== {4'hA, 6'd4, 1'b1}) begin
            failures++;
            $display("[TB] FAIL timeout_keep got A=%0h Op=%0d Sel=%0b required A=a Op=4 Sel=1",
                     bus.A_Out, bus.Op_Out, bus.Sel_Out);
        end

        drive_beat(4'h6, 6'd1, 1'b0);
        tick();
        bus.Data_Valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (timeout_err) pulses++;
        end
        drive_beat(4'h2, 6'd0, 1'b0);
        bus.Alsu_Result   = 4'h8;
        bus.Alsu_Neg_Flag = 1'b1;
        tick();
        bus.Data_Valid = 1'b0;
        checks++;
        if ({timeout_err, busy, bus.Data_Ready, bus.B_Out} !== {1'b0, 1'b1, 1'b0, 4'h2} || pulses !== 0) begin
            failures++;
            $display("[TB] FAIL late_b_accept got err=%0b early_errs=%0d busy=%0b ready=%0b B=%0h required err=0 early_errs=0 busy=1 ready=0 B=2",
                     timeout_err, pulses, busy, bus.Data_Ready, bus.B_Out);
        end
        tick();
        checks++;
        if ({bus.Result, bus.Negative_Sign_Flag, bus.Result_Valid, timeout_err} !== {4'h8, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL late_b_result got R=%0h N=%0b V=%0b err=%0b required R=8 N=1 V=1 err=0",
                     bus.Result, bus.Negative_Sign_Flag, bus.Result_Valid, timeout_err);
        end
        bus.Result_Ack = 1'b1;
        tick();
        bus.Result_Ack = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        drive_beat(4'hC, 6'd3, 1'b0);
        tick();
        drive_beat(4'h1, 6'd0, 1'b0);
        tick();
        bus.Data_Valid  = 1'b0;
        bus.Alsu_Result = 4'hD;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.Result_Valid, bus.Result, busy, bus.A_Out} !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset_in_exec got V=%0b R=%0h busy=%0b A=%0h required all 0",
                     bus.Result_Valid, bus.Result, busy, bus.A_Out);
        end
        drive_beat(4'h9, 6'd2, 1'b1);
        tick();
        checks++;
        if ({busy, bus.A_Out} !== {1'b1, 4'h9}) begin
            failures++;
            $display("[TB] FAIL accept_after_exec_reset got busy=%0b A=%0h required busy=1 A=9", busy, bus.A_Out);
        end
        drive_beat(4'h2, 6'd0, 1'b0);
        tick();
        bus.Data_Valid    = 1'b0;
        bus.Alsu_Result   = 4'hE;
        bus.Alsu_Neg_Flag = 1'b1;
        tick();
        checks++;
        if ({bus.Result_Valid, bus.Result} !== {1'b1, 4'hE}) begin
            failures++;
            $display("[TB] FAIL hold_before_reset got V=%0b R=%0h required V=1 R=e", bus.Result_Valid, bus.Result);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.Result_Valid, bus.Result, bus.Negative_Sign_Flag, busy} !== 7'd0) begin
            failures++;
            $display("[TB] FAIL reset_in_hold got V=%0b R=%0h N=%0b busy=%0b required all 0",
                     bus.Result_Valid, bus.Result, bus.Negative_Sign_Flag, busy);
        end
        drive_beat(4'h3, 6'd5, 1'b0);
        tick();
        checks++;
        if ({busy, bus.A_Out} !== {1'b1, 4'h3}) begin
            failures++;
            $display("[TB] FAIL accept_after_hold_reset got busy=%0b A=%0h required busy=1 A=3", busy, bus.A_Out);
        end
        bus.Data_Valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int results;
        logic exp_ready;
        logic exp_valid;
        logic exp_busy;
        bus.Alsu_Result   = 4'h9;
        bus.Alsu_Neg_Flag = 1'b0;
        bus.Result_Ack    = 1'b1;
        drive_beat(4'h7, 6'd12, 1'b0);
        results = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            case ((i - 1) % 4)
                0:       begin exp_ready = 1'b1; exp_valid = 1'b0; exp_busy = 1'b1; end
                1:       begin exp_ready = 1'b0; exp_valid = 1'b0; exp_busy = 1'b1; end
                2:       begin exp_ready = 1'b0; exp_valid = 1'b1; exp_busy = 1'b1; end
                default: begin exp_ready = 1'b1; exp_valid = 1'b0; exp_busy = 1'b0; end
            endcase
            if (bus.Result_Valid) results++;
            checks++;
            if ({bus.Data_Ready, bus.Result_Valid, busy} !== {exp_ready, exp_valid, exp_busy}) begin
                failures++;
                $display("[TB] FAIL b2b_phase tick=%0d got ready=%0b V=%0b busy=%0b required ready=%0b V=%0b busy=%0b",
                         i, bus.Data_Ready, bus.Result_Valid, busy, exp_ready, exp_valid, exp_busy);
            end
        end
        checks++;
        if (results !== 3 || bus.Result !== 4'h9) begin
            failures++;
            $display("[TB] FAIL b2b_results got count=%0d R=%0h required count=3 R=9", results, bus.Result);
        end
        bus.Data_Valid = 1'b0;
        bus.Result_Ack = 1'b0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_op();
        test_decrement_hold();
        test_timeout();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
